// File: rtl/timer_regs_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | timer_regs_pkg: register map, CTRL/STATUS bit indices, handshake states |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
package timer_regs_pkg;

    localparam int REG_CTRL      = 0;
    localparam int REG_TERMCOUNT = 1;
    localparam int REG_STATUS    = 2;
    localparam int REG_CURRCOUNT = 3;
    localparam int REG_INTCLR    = 4;

    localparam int CTRL_START = 0;
    localparam int CTRL_HALT  = 1;
    localparam int CTRL_MODE  = 2;
    localparam int CTRL_IE    = 3;

    localparam int STAT_RUN     = 0;
    localparam int STAT_INTPEND = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/timer_int_capture.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | timer_int_capture: rf_int edge detect, sticky pending, masked irq       |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module timer_int_capture (
    input  logic clk,
    input  logic reset,
    input  logic rf_int_i,
    input  logic int_clr_i,
    input  logic ie_i,
    output logic int_pending_o,
    output logic irq_o
);

    logic rf_int_d_q;
    logic int_pending_q;
    logic irq_q;
    logic w_rise;

    assign w_rise = rf_int_i & ~rf_int_d_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_int_d_q    <= 1'b0;
            int_pending_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            rf_int_d_q <= rf_int_i;
            // A new edge outranks a simultaneous clear so no event is lost.
            if (w_rise) begin
                int_pending_q <= 1'b1;
            end else if (int_clr_i) begin
                int_pending_q <= 1'b0;
            end
            irq_q <= int_pending_q & ie_i;
        end
    end

    assign int_pending_o = int_pending_q;
    assign irq_o         = irq_q;

endmodule
`default_nettype wire

// File: rtl/timer_regfile.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | timer_regfile: bus register block driving the timing core's controls.   |
// | Option: TIMER_REGFILE_SHADOW_EN - STATUS read snapshots the count.      |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module timer_regfile
    import timer_regs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_sel,
    input  logic              bus_wr,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_ready,
    output logic              irq,
    output logic              ro_trig_start,
    output logic              ro_trig_halt,
    output logic              ro_mode,
    output logic [DATA_W-1:0] ro_termcount,
    input  logic              rf_status,
    input  logic [DATA_W-1:0] rf_currcount,
    input  logic              rf_int
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;
    logic              trig_start_q;
    logic              trig_halt_q;
    logic              mode_q;
    logic              ie_q;
    logic [DATA_W-1:0] termcount_q;
    logic [DATA_W-1:0] w_rdata;
    logic              w_commit;
    logic              w_wr_ctrl;
    logic              w_wr_term;
    logic              w_int_clr;
    logic              w_int_pending;

    // Everything commits on the single edge that moves IDLE -> ACK.
    assign w_commit  = (state_q == ST_IDLE) && bus_sel;
    assign w_wr_ctrl = w_commit && bus_wr && (bus_addr == ADDR_W'(REG_CTRL));
    assign w_wr_term = w_commit && bus_wr && (bus_addr == ADDR_W'(REG_TERMCOUNT));
    assign w_int_clr = w_commit && bus_wr && (bus_addr == ADDR_W'(REG_INTCLR))
                       && bus_wdata[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus_sel) state_d = ST_ACK;
            ST_ACK:     state_d = ST_RELEASE;
            ST_RELEASE: if (!bus_sel) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

`ifdef TIMER_REGFILE_SHADOW_EN
    logic [DATA_W-1:0] shadow_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_q <= '0;
        end else if (w_commit && !bus_wr && (bus_addr == ADDR_W'(REG_STATUS))) begin
            shadow_q <= rf_currcount;
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        case (bus_addr)
            ADDR_W'(REG_CTRL): begin
                w_rdata[CTRL_MODE] = mode_q;
                w_rdata[CTRL_IE]   = ie_q;
            end
            ADDR_W'(REG_TERMCOUNT): w_rdata = termcount_q;
            ADDR_W'(REG_STATUS): begin
                w_rdata[STAT_RUN]     = rf_status;
                w_rdata[STAT_INTPEND] = w_int_pending;
            end
`ifdef TIMER_REGFILE_SHADOW_EN
            ADDR_W'(REG_CURRCOUNT): w_rdata = shadow_q;
`else
            ADDR_W'(REG_CURRCOUNT): w_rdata = rf_currcount;
`endif
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q      <= '0;
            ready_q      <= 1'b0;
            trig_start_q <= 1'b0;
            trig_halt_q  <= 1'b0;
            mode_q       <= 1'b0;
            ie_q         <= 1'b0;
            termcount_q  <= '0;
        end else begin
            ready_q      <= w_commit;
            // HALT takes precedence when both trigger bits are written.
            trig_start_q <= w_wr_ctrl && bus_wdata[CTRL_START] && !bus_wdata[CTRL_HALT];
            trig_halt_q  <= w_wr_ctrl && bus_wdata[CTRL_HALT];
            if (w_commit) begin
                rdata_q <= bus_wr ? '0 : w_rdata;
            end
            if (w_wr_ctrl) begin
                ie_q <= bus_wdata[CTRL_IE];
                if (!rf_status) begin
                    mode_q <= bus_wdata[CTRL_MODE];
                end
            end
            if (w_wr_term && !rf_status) begin
                termcount_q <= bus_wdata;
            end
        end
    end

    timer_int_capture u_int_capture (
        .clk           (clk),
        .reset         (reset),
        .rf_int_i      (rf_int),
        .int_clr_i     (w_int_clr),
        .ie_i          (ie_q),
        .int_pending_o (w_int_pending),
        .irq_o         (irq)
    );

    assign bus_rdata     = rdata_q;
    assign bus_ready     = ready_q;
    assign ro_trig_start = trig_start_q;
    assign ro_trig_halt  = trig_halt_q;
    assign ro_mode       = mode_q;
    assign ro_termcount  = termcount_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_regfile.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_timer_regfile: directed self-checking bench for timer_regfile        |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module tb_timer_regfile;

    logic        clk;
    logic        reset;
    logic        bus_sel;
    logic        bus_wr;
    logic [2:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        irq;
    logic        ro_trig_start;
    logic        ro_trig_halt;
    logic        ro_mode;
    logic [31:0] ro_termcount;
    logic        rf_status;
    logic [31:0] rf_currcount;
    logic        rf_int;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] rd;
    logic        st_seen, ht_seen, st_after, ht_after;
    int          rdy_cnt, st_cnt;

    timer_regfile #(.DATA_W(32), .ADDR_W(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_sel       (bus_sel),
        .bus_wr        (bus_wr),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_ready     (bus_ready),
        .irq           (irq),
        .ro_trig_start (ro_trig_start),
        .ro_trig_halt  (ro_trig_halt),
        .ro_mode       (ro_mode),
        .ro_termcount  (ro_termcount),
        .rf_status     (rf_status),
        .rf_currcount  (rf_currcount),
        .rf_int        (rf_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a posedge with the FSM idle; returns #1 after the edge
    // on which the FSM is back in IDLE.
    task automatic bus_acc(input logic [2:0] a, input logic w, input logic [31:0] d,
                           output logic [31:0] rdo);
        int lat;
        lat = 0;
        bus_sel = 1'b1; bus_wr = w; bus_addr = a; bus_wdata = d;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus_ready && lat < 8);
        chk("ack_latency", 32'(lat), 32'd1);
        rdo = bus_rdata; st_seen = ro_trig_start; ht_seen = ro_trig_halt;
        bus_sel = 1'b0; bus_wr = 1'b0; bus_wdata = '0;
        @(posedge clk); #1;
        chk("ack_width", {31'd0, bus_ready}, 32'd0);
        st_after = ro_trig_start; ht_after = ro_trig_halt;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0; bus_sel = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
        rf_status = 1'b0; rf_currcount = '0; rf_int = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("rst_ready", {31'd0, bus_ready}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_start", {31'd0, ro_trig_start}, 32'd0);
        chk("rst_halt", {31'd0, ro_trig_halt}, 32'd0);
        chk("rst_mode", {31'd0, ro_mode}, 32'd0);
        chk("rst_term", ro_termcount, 32'd0);

        for (int i = 0; i < 8; i++) begin
            bus_acc(3'(i), 1'b0, 32'd0, rd);
            chk("rst_read", rd, 32'd0);
        end

        bus_acc(3'd1, 1'b1, 32'h10, rd);
        bus_acc(3'd0, 1'b1, 32'h5, rd);
        chk("start_pulse", {31'd0, st_seen}, 32'd1);
        chk("start_1cyc", {31'd0, st_after}, 32'd0);
        chk("start_nohalt", {31'd0, ht_seen}, 32'd0);
        chk("term_0x10", ro_termcount, 32'h10);
        chk("mode_set", {31'd0, ro_mode}, 32'd1);
        bus_acc(3'd0, 1'b0, 32'd0, rd);
        chk("ctrl_read", rd, 32'h4);

        rf_status = 1'b1;
        bus_acc(3'd1, 1'b1, 32'h20, rd);
        chk("term_locked", ro_termcount, 32'h10);
        bus_acc(3'd1, 1'b0, 32'd0, rd);
        chk("term_read", rd, 32'h10);
        bus_acc(3'd0, 1'b1, 32'h3, rd);
        chk("both_halt", {31'd0, ht_seen}, 32'd1);
        chk("both_nostart", {31'd0, st_seen}, 32'd0);
        chk("halt_1cyc", {31'd0, ht_after}, 32'd0);
        chk("mode_locked", {31'd0, ro_mode}, 32'd1);
        bus_acc(3'd2, 1'b0, 32'd0, rd);
        chk("status_run", rd, 32'h1);
        rf_status = 1'b0;

        bus_acc(3'd0, 1'b1, 32'hC, rd);
        rf_int = 1'b1;
        @(posedge clk); #1;
        chk("irq_lag", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        chk("irq_set", {31'd0, irq}, 32'd1);
        bus_acc(3'd2, 1'b0, 32'd0, rd);
        chk("status_pend", rd, 32'h2);

        rf_int = 1'b0;
        repeat (2) @(posedge clk);
        #1 rf_int = 1'b1;
        bus_acc(3'd4, 1'b1, 32'h1, rd);
        chk("set_wins_irq", {31'd0, irq}, 32'd1);
        bus_acc(3'd2, 1'b0, 32'd0, rd);
        chk("set_wins_pend", rd, 32'h2);
        bus_acc(3'd4, 1'b1, 32'h1, rd);
        chk("clr_irq", {31'd0, irq}, 32'd0);
        bus_acc(3'd2, 1'b0, 32'd0, rd);
        chk("clr_pend", rd, 32'h0);
        bus_acc(3'd4, 1'b0, 32'd0, rd);
        chk("intclr_read", rd, 32'h0);

        rf_int = 1'b0;
        @(posedge clk);
        #1 rf_int = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("irq_again", {31'd0, irq}, 32'd1);
        bus_acc(3'd0, 1'b1, 32'h4, rd);
        chk("ie_off_irq", {31'd0, irq}, 32'd0);
        bus_acc(3'd2, 1'b0, 32'd0, rd);
        chk("ie_off_pend", rd, 32'h2);
        bus_acc(3'd4, 1'b1, 32'h1, rd);
        rf_int = 1'b0;

        rdy_cnt = 0; st_cnt = 0;
        bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = 3'd0; bus_wdata = 32'h5;
        repeat (6) begin
            @(posedge clk); #1;
            rdy_cnt += int'(bus_ready); st_cnt += int'(ro_trig_start);
        end
        bus_sel = 1'b0; bus_wr = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            rdy_cnt += int'(bus_ready); st_cnt += int'(ro_trig_start);
        end
        chk("held_ready_cnt", 32'(rdy_cnt), 32'd1);
        chk("held_start_cnt", 32'(st_cnt), 32'd1);

        bus_acc(3'd6, 1'b1, 32'hFFFF_FFFF, rd);
        bus_acc(3'd6, 1'b0, 32'd0, rd);
        chk("unmapped_read", rd, 32'd0);

        rf_currcount = 32'h100;
        bus_acc(3'd2, 1'b0, 32'd0, rd);
        rf_currcount = 32'h180;
        bus_acc(3'd3, 1'b0, 32'd0, rd);
`ifdef TIMER_REGFILE_SHADOW_EN
        chk("currcount", rd, 32'h100);
`else
        chk("currcount", rd, 32'h180);
`endif

        bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = 3'd0; bus_wdata = 32'h1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready", {31'd0, bus_ready}, 32'd0);
        chk("midrst_start", {31'd0, ro_trig_start}, 32'd0);
        bus_sel = 1'b0; bus_wr = 1'b0;
        @(posedge clk); #1;
        chk("midrst_start2", {31'd0, ro_trig_start}, 32'd0);
        chk("midrst_mode", {31'd0, ro_mode}, 32'd0);
        chk("midrst_term", ro_termcount, 32'd0);
        reset = 1'b1;
        bus_acc(3'd1, 1'b0, 32'd0, rd);
        chk("post_rst_term", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/timer_regfile.md
Name: timer_regfile

Overview:
Bus-side register block that controls the `timing` timer core. It drives the core's ro_* control inputs and captures its rf_* status and count outputs. It converts single-word bus reads and writes into one-cycle start/halt trigger pulses, a held mode and terminal count, and a sticky, maskable interrupt. It sits between the system bus slave mux and the `timing` instance.

Parameters:
DATA_W, 32, bus data width; also the width of termcount and currcount
ADDR_W, 3, word-address width; word-indexed register offsets

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-low; clock clk
bus_sel  in  1  access request; held high until bus_ready is seen
bus_wr  in  1  1 = write, 0 = read; valid while bus_sel is high
bus_addr  in  ADDR_W  register word offset
bus_wdata  in  DATA_W  write data
bus_rdata  out  DATA_W  read data; valid only while bus_ready is high
bus_ready  out  1  one-cycle access acknowledge
irq  out  1  interrupt to the system; equals int_pending & IE
ro_trig_start  out  1  one-cycle start pulse to the timer
ro_trig_halt  out  1  one-cycle halt pulse to the timer
ro_mode  out  1  timer mode, held
ro_termcount  out  DATA_W  terminal count, held
rf_status  in  1  timer running flag
rf_currcount  in  DATA_W  live timer count
rf_int  in  1  timer terminal-count indication (level)

Behaviour:
- Reset values (when reset == 0 at a clk edge): bus_rdata 0, bus_ready 0, irq 0, ro_trig_start 0, ro_trig_halt 0, ro_mode 0, ro_termcount 0, IE 0, int_pending 0, rf_int_d 0. FSM goes to IDLE.
- Register map:
  - 0 CTRL (W/RW):
    - bit0 START: write-1 pulse, reads 0.
    - bit1 HALT: write-1 pulse, reads 0.
    - bit2 MODE: RW.
    - bit3 IE: RW.
  - 1 TERMCOUNT: RW.
  - 2 STATUS (RO): bit0 rf_status, bit1 int_pending.
  - 3 CURRCOUNT (RO): rf_currcount.
  - 4 INTCLR (W1C): writing bit0 = 1 clears int_pending; reads 0.
  - 5..7: unmapped. Reads return 0, writes are ignored, the access is still acknowledged.
- Handshake FSM:
  - IDLE: on bus_sel = 1, go to ACK.
  - ACK: bus_ready = 1 for exactly one cycle. bus_rdata is registered on entry to ACK. The write side effect commits on the same edge that enters ACK. Next state is RELEASE.
  - RELEASE: wait for bus_sel = 0, then go to IDLE. This stops a held bus_sel from causing a double write.
  - Latency: bus_ready rises on the 1st edge after bus_sel is sampled high. Minimum period is 3 cycles per access.
- Trigger pulses: ro_trig_start and ro_trig_halt are registered and last exactly 1 cycle, on the cycle after the committing edge.
  - START and HALT written together: HALT pulses, START is suppressed.
- Lock while running: while rf_status = 1, writes to MODE and TERMCOUNT are ignored (old value kept, access still acked). IE is still writable.
- Interrupt capture:
  - rf_int_d registers rf_int.
  - A rising edge (rf_int & ~rf_int_d) sets int_pending.
  - A set in the same cycle as an INTCLR write: set wins, pending stays 1.
  - irq is registered: irq = int_pending & IE, one cycle behind int_pending.
  - Clearing IE drops irq on the next edge; int_pending is retained.
- CURRCOUNT read returns rf_currcount as sampled at the edge entering ACK.
- Reset asserted mid-access: FSM returns to IDLE and no pulse is issued. The master re-issues the access.
- Widths: all RW fields are DATA_W. Unused read bits return 0.

Optional Feature:
TIMER_REGFILE_SHADOW_EN
- Defined:
  - A STATUS read also latches rf_currcount into shadow_count (reset 0).
  - A CURRCOUNT read returns shadow_count, so status and count form a coherent pair.
- Undefined: no shadow register; CURRCOUNT returns the live sample.

Decomposition:
- Package timer_regs_pkg holds:
  - register offset constants (CTRL = 0 … INTCLR = 4);
  - CTRL bit indices (START = 0, HALT = 1, MODE = 2, IE = 3) and STATUS bit indices;
  - the FSM state enum {IDLE, ACK, RELEASE}.
- One sub-module, timer_int_capture: rf_int edge detect, int_pending set/clear priority, irq masking.

Test Plan:
- Reset, then read each of offsets 0..7 -> all return 0; bus_ready high exactly 1 cycle per access; all ro_* = 0.
- Write TERMCOUNT = 0x0000_0010, write CTRL = 0x5 (START | MODE) -> ro_termcount = 0x10, ro_mode = 1, ro_trig_start high exactly 1 cycle.
- With rf_status = 1, write TERMCOUNT = 0x20 -> ro_termcount stays 0x10. Write CTRL = 0x3 -> only ro_trig_halt pulses.
- IE = 1, rf_int 0→1 -> int_pending = 1 and irq = 1 the next cycle. Drive an INTCLR write on the same cycle as a second rf_int rising edge -> pending stays 1. A lone INTCLR then clears irq.
- Hold bus_sel high for 6 cycles on a CTRL START write -> exactly one bus_ready and one ro_trig_start.
- With TIMER_REGFILE_SHADOW_EN: rf_currcount = 0x100 at the STATUS read, then 0x180 -> the following CURRCOUNT read returns 0x100. Without the macro, it returns 0x180.
